conv_output_collector: RTL and testbench

// Downstream of the convolution controller/datapath. Captures each final output pixel (output_valid pulse + x/y/ch + accumulator).

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_output_collector_if.sv | 32 +++
 rtl/sync_fifo_fwft.sv | 67 ++++++
 rtl/conv_output_collector.sv | 150 +++++++++++++++
 tb/tb_conv_output_collector.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output collector: collector FSM
// state type, coordinate width and the per-layer output count helper.
package conv_pkg;

  localparam int unsigned COORD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } collector_state_e;

  // Number of output pixels a layer delivers to the host.
  function automatic logic [31:0] total_outputs(input int unsigned w,
                                                input int unsigned h,
                                                input int unsigned c);
    return 32'(w * h * c);
  endfunction

endpackage

// File: rtl/conv_output_collector_if.sv
// Pixel bus of the output collector: result pixels in from the datapath,
// requantised pixels out to the host over valid/ready.
// master: datapath + host side; slave: collector side.
interface conv_output_collector_if #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_WIDTH = 16
);

  logic                                 in_valid;
  logic [ACC_WIDTH-1:0]                 in_data;
  logic [conv_pkg::COORD_WIDTH-1:0]     in_x;
  logic [conv_pkg::COORD_WIDTH-1:0]     in_y;
  logic [conv_pkg::COORD_WIDTH-1:0]     in_ch;

  logic                                 out_valid;
  logic                                 out_ready;
  logic [OUT_WIDTH-1:0]                 out_data;
  logic [conv_pkg::COORD_WIDTH-1:0]     out_x;
  logic [conv_pkg::COORD_WIDTH-1:0]     out_y;
  logic [conv_pkg::COORD_WIDTH-1:0]     out_ch;

  modport master (
    output in_valid, in_data, in_x, in_y, in_ch, out_ready,
    input  out_valid, out_data, out_x, out_y, out_ch
  );

  modport slave (
    input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
    output out_valid, out_data, out_x, out_y, out_ch
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. Head word is presented on
// rd_data whenever the FIFO is non-empty (zero when empty). A push and a
// pop in the same cycle are both accepted even when full. clear empties
// the FIFO synchronously and takes priority over push/pop.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/conv_output_collector.sv
// Convolution output collector: captures final output pixels, requantises
// the accumulator (arithmetic shift + saturation), buffers the result in a
// FWFT FIFO and streams it to the host. Counts delivered pixels and pulses
// done on the last one of a layer. The producer cannot be stalled, so a
// push into a full FIFO drops the pixel and sets the sticky overflow flag.
// Build option: OUTPUT_RELU_EN forces negative requantised values to zero.
module conv_output_collector
  import conv_pkg::*;
#(
  parameter int unsigned ACC_WIDTH          = 32,
  parameter int unsigned OUT_WIDTH          = 16,
  parameter int unsigned SHIFT              = 8,
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  conv_output_collector_if.slave        bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          done
);

  localparam int unsigned ENTRY_W = OUT_WIDTH + 3 * COORD_WIDTH;
  localparam logic [31:0] TOTAL =
    total_outputs(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  collector_state_e state;
  logic [31:0]      popped_cnt;

  logic signed [ACC_WIDTH-1:0] shifted;
  logic [OUT_WIDTH-1:0]        sat_word;
  logic [OUT_WIDTH-1:0]        q_word;

  logic                        stage_valid;
  logic [OUT_WIDTH-1:0]        stage_word;
  logic [COORD_WIDTH-1:0]      stage_x;
  logic [COORD_WIDTH-1:0]      stage_y;
  logic [COORD_WIDTH-1:0]      stage_ch;

  logic                        capture;
  logic                        clr;
  logic                        pop;
  logic                        drop;
  logic                        last_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [ENTRY_W-1:0]          fifo_wr;
  logic [ENTRY_W-1:0]          fifo_rd;

  assign capture  = bus.in_valid && (state == COLLECT);
  assign clr      = start && (state != COLLECT);
  assign pop      = bus.out_valid && bus.out_ready;
  assign drop     = stage_valid && fifo_full && !pop;
  assign last_pop = (state == COLLECT) && pop && (popped_cnt == TOTAL - 32'd1);
  assign done     = last_pop;

  // Requantise: arithmetic shift, saturate to OUT_WIDTH, optional ReLU.
  always_comb begin
    shifted = $signed(bus.in_data) >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_word = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_word = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      sat_word = shifted[OUT_WIDTH-1:0];
    end
`ifdef OUTPUT_RELU_EN
    q_word = sat_word[OUT_WIDTH-1] ? '0 : sat_word;
`else
    q_word = sat_word;
`endif
  end

  // Stage 1: register the requantised word and coordinates of a captured pixel.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stage_valid <= 1'b0;
      stage_word  <= '0;
      stage_x     <= '0;
      stage_y     <= '0;
      stage_ch    <= '0;
    end else begin
      stage_valid <= capture;
      if (capture) begin
        stage_word <= q_word;
        stage_x    <= bus.in_x;
        stage_y    <= bus.in_y;
        stage_ch   <= bus.in_ch;
      end
    end
  end

  assign fifo_wr = {stage_word, stage_x, stage_y, stage_ch};

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .clear     (clr),
    .push      (stage_valid),
    .wr_data   (fifo_wr),
    .pop       (pop),
    .rd_data   (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bus.out_valid = !fifo_empty;
  assign {bus.out_data, bus.out_x, bus.out_y, bus.out_ch} = fifo_rd;

  // Layer FSM with delivered-pixel counter and sticky overflow flag.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state      <= IDLE;
      popped_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (start) state <= COLLECT;
        COLLECT: if (last_pop) state <= DONE;
        DONE:    state <= start ? COLLECT : IDLE;
        default: state <= IDLE;
      endcase

      if (clr) begin
        popped_cnt <= '0;
      end else if ((state == COLLECT) && pop) begin
        popped_cnt <= popped_cnt + 32'd1;
      end

      if (clr) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_output_collector.sv
// Self-checking bench for conv_output_collector (W=H=C=2, SHIFT=8,
// FIFO_DEPTH=8). Expected pixels are queued when driven and compared as
// the host side accepts them.
module tb_conv_output_collector;

  localparam int unsigned TOTAL = 8;

  typedef struct {
    logic [15:0] d;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } exp_t;

  logic       clk;
  logic       arst_n_in;
  logic       start;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       done;

  int   n_checks = 0;
  int   n_errors = 0;
  int   pops = 0;
  int   layer_base = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];

  conv_output_collector_if #(.ACC_WIDTH(32), .OUT_WIDTH(16)) bus ();

  conv_output_collector #(
    .ACC_WIDTH          (32),
    .OUT_WIDTH          (16),
    .SHIFT              (8),
    .FIFO_DEPTH         (8),
    .FEATURE_MAP_WIDTH  (2),
    .FEATURE_MAP_HEIGHT (2),
    .OUTPUT_NB_CHANNELS (2)
  ) dut (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .start      (start),
    .bus        (bus),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference requantiser: floor division by 256, clamp, optional ReLU.
  function automatic logic [15:0] model_q(input logic [31:0] d);
    longint v;
    v = longint'($signed(d));
    v = (v - (((v % 256) + 256) % 256)) / 256;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`ifdef OUTPUT_RELU_EN
    if (v < 0) v = 0;
`endif
    return 16'(v);
  endfunction

  // One clock: host-side scoreboard at the falling edge, then return 1 time
  // unit after the rising edge so inputs can be driven.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_pop", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("out_data", bus.out_data, e.d);
        check("out_x", bus.out_x, e.x);
        check("out_y", bus.out_y, e.y);
        check("out_ch", bus.out_ch, e.ch);
      end
      check("done_on_pop", done, ((pops - layer_base) == TOTAL - 1) ? 1 : 0);
      pops++;
    end else begin
      check("done_idle", done, 0);
    end
    if (done === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] ch, input bit accept);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_ch    = ch;
    if (accept) sb_q.push_back('{model_q(d), x, y, ch});
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    layer_base = pops;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) tick();
    check(tag, sb_q.size(), 0);
    tick();
  endtask

  logic [31:0] sat_vals [8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FF00,
                                32'h0001_2345, 32'hFFFF_FFFF, 32'h0001_0000,
                                32'h00FF_FFFF, 32'hFF00_0000};

  initial begin
    int d0;
    arst_n_in     = 1'b0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_ch     = '0;
    bus.out_ready = 1'b0;
    #23;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_x", bus.out_x, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_done", done, 0);
    arst_n_in = 1'b1;
    tick();

    // Pixels while IDLE are ignored.
    for (int i = 0; i < 3; i++) send(32'h300, i, 0, 0, 0);
    repeat (3) tick();
    check("idle_level", fifo_level, 0);
    check("idle_overflow", overflow, 0);
    check("idle_out_valid", bus.out_valid, 0);

    // Basic layer: 8 pixels of 0x300 -> 3, two-cycle latency, done on 8th.
    d0 = done_cnt;
    do_start();
    bus.out_ready = 1'b1;
    send(32'h300, 0, 0, 0, 1);
    check("lat_t1", bus.out_valid, 0);
    tick();
    check("lat_t2_valid", bus.out_valid, 1);
    check("lat_t2_data", bus.out_data, 16'd3);
    for (int i = 1; i < 8; i++) send(32'h300, i % 2, (i / 2) % 2, i / 4, 1);
    drain("drain_basic");
    check("done_count_basic", done_cnt - d0, 1);
    // Back in IDLE: further pixels ignored.
    send(32'h300, 0, 0, 0, 0);
    repeat (3) tick();
    check("post_done_level", fifo_level, 0);
    check("post_done_valid", bus.out_valid, 0);

    // Saturation / sign handling.
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 8; i++) send(sat_vals[i], i, 1, 1, 1);
    drain("drain_sat");
    check("done_count_sat", done_cnt - d0, 1);

    // Fill, full push+pop, then overflow with stalled host.
    d0 = done_cnt;
    do_start();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send((i + 1) << 8, i + 10, i + 20, i + 30, 1);
    repeat (2) tick();
    check("full_level", fifo_level, 8);
    check("full_overflow", overflow, 0);
    send(32'h900, 18, 28, 38, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pushpop_level", fifo_level, 8);
    check("pushpop_overflow", overflow, 0);
    tick();
    check("pushpop_level2", fifo_level, 8);
    send(32'hA00, 19, 29, 39, 0);
    tick();
    check("ovf_set", overflow, 1);
    check("ovf_level", fifo_level, 8);
    send(32'hB00, 20, 30, 40, 0);
    tick();
    check("ovf_level2", fifo_level, 8);
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, sb_q[0].d);
      check("stall_x", bus.out_x, sb_q[0].x);
      check("stall_y", bus.out_y, sb_q[0].y);
      check("stall_ch", bus.out_ch, sb_q[0].ch);
      tick();
    end
    bus.out_ready = 1'b1;
    drain("drain_full");
    check("done_count_full", done_cnt - d0, 1);
    check("ovf_sticky", overflow, 1);

    // Asynchronous reset mid-layer with 5 queued.
    do_start();
    check("start_clears_ovf", overflow, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h500, i, 0, 0, 1);
    repeat (2) tick();
    check("pre_rst_level", fifo_level, 5);
    arst_n_in = 1'b0;
    #1;
    sb_q.delete();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_ch", bus.out_ch, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_done", done, 0);
    #2;
    arst_n_in = 1'b1;
    tick();
    d0 = done_cnt;
    do_start();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h0000_1000 + i, i % 2, (i / 2) % 2, i / 4, 1);
    drain("drain_after_rst");
    check("done_count_rst", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
